// File: rtl/dm_sba_master_pkg.sv
// Shared types and constants for the system bus access master.
// State encoding, error codes and sbaccess size codes.
package dm_sba_master_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } sba_state_e;

  localparam logic [2:0] SBErrNone    = 3'd0;
  localparam logic [2:0] SBErrTimeout = 3'd1;
  localparam logic [2:0] SBErrBadAddr = 3'd2;
  localparam logic [2:0] SBErrAlign   = 3'd3;
  localparam logic [2:0] SBErrSize    = 3'd4;

  localparam logic [2:0] SBAccess8  = 3'd0;
  localparam logic [2:0] SBAccess16 = 3'd1;
  localparam logic [2:0] SBAccess32 = 3'd2;

  function automatic logic sba_misaligned(input logic [2:0] access, input logic [1:0] addr_lo);
    logic res;
    res = 1'b0;
    if (access == SBAccess16) res = addr_lo[0];
    if (access == SBAccess32) res = |addr_lo;
    return res;
  endfunction

endpackage

// File: rtl/dm_sba_master_if.sv
// System bus port of the SBA master: req/gnt request phase, r_valid response phase.
interface dm_sba_master_if #(
  parameter int BusWidth = 32
) ();

  logic                req;
  logic [BusWidth-1:0] add;
  logic                we;
  logic [31:0]         wdata;
  logic [3:0]          be;
  logic                gnt;
  logic                r_valid;
  logic                r_err;
  logic [31:0]         r_rdata;

  modport master (
    output req, add, we, wdata, be,
    input  gnt, r_valid, r_err, r_rdata
  );

  modport slave (
    input  req, add, we, wdata, be,
    output gnt, r_valid, r_err, r_rdata
  );

endinterface

// File: rtl/dm_sba_lane_align.sv
// Byte-lane steering: write-side byte enables and replicated data, read-side
// lane extraction with zero extension.
module dm_sba_lane_align
  import dm_sba_master_pkg::*;
(
  input  logic [2:0]  wr_access,
  input  logic [1:0]  wr_offset,
  input  logic [31:0] wdata_in,
  input  logic [2:0]  rd_access,
  input  logic [1:0]  rd_offset,
  input  logic [31:0] rdata_in,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] rdata
);

  logic [3:0]  be_base;
  logic [31:0] rdata_shifted;

  always_comb begin
    be_base = 4'b0000;
    case (wr_access)
      SBAccess8:  be_base = 4'b0001;
      SBAccess16: be_base = 4'b0011;
      SBAccess32: be_base = 4'b1111;
      default:    be_base = 4'b0000;
    endcase
  end

  assign be = be_base << wr_offset;

  // Each lane takes the byte of the access-sized value that lands on it.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign wdata[8*gi +: 8] = (wr_access == SBAccess8)  ? wdata_in[7:0] :
                              (wr_access == SBAccess16) ? wdata_in[8*(gi%2) +: 8] :
                                                          wdata_in[8*gi +: 8];
  end

  assign rdata_shifted = rdata_in >> {rd_offset, 3'b000};

  always_comb begin
    rdata = rdata_shifted;
    case (rd_access)
      SBAccess8:  rdata = {24'h0, rdata_shifted[7:0]};
      SBAccess16: rdata = {16'h0, rdata_shifted[15:0]};
      default:    rdata = rdata_shifted;
    endcase
  end

endmodule

// File: rtl/dm_sba_master.sv
// SBA master FSM: turns register-file trigger pulses into single bus transactions.
// Optional macro SBA_TIMEOUT_EN adds a grant/response timeout counter.
module dm_sba_master
  import dm_sba_master_pkg::*;
#(
  parameter int BusWidth      = 32,
  parameter int TimeoutCycles = 256
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] sbaddress_i,
  input  logic [31:0] sbdata_i,
  input  logic [2:0]  sbaccess_i,
  input  logic        sbautoincrement_i,
  input  logic        sbreadonaddr_i,
  input  logic        sbreadondata_i,
  input  logic        sbaddress_write_valid_i,
  input  logic        sbdata_read_valid_i,
  input  logic        sbdata_write_valid_i,
  output logic [31:0] sbaddress_o,
  output logic [31:0] sbdata_o,
  output logic        sbdata_valid_o,
  output logic        sberror_valid_o,
  output logic [2:0]  sberror_o,
  output logic        sbbusy_o,
  dm_sba_master_if.master bus
);

  sba_state_e          state_reg;
  logic [31:0]         addr_reg;
  logic [2:0]          access_reg;
  logic                autoinc_reg;
  logic [31:0]         rdata_reg;
  logic                err_reg;
  logic                req_reg;
  logic [BusWidth-1:0] add_reg;
  logic                we_reg;
  logic [31:0]         wdata_reg;
  logic [3:0]          be_reg;
  logic [31:0]         sbdata_reg;
  logic                sbdata_valid_reg;
  logic                sberror_valid_reg;
  logic [2:0]          sberror_reg;
  logic                busy_reg;

  logic                trig_dw, trig_aw, trig_dr, trig_any;
  logic [31:0]         eff_addr;
  logic [3:0]          be_next;
  logic [31:0]         wdata_next;
  logic [31:0]         rdata_lane;

  assign trig_dw  = sbdata_write_valid_i;
  assign trig_aw  = sbaddress_write_valid_i & sbreadonaddr_i;
  assign trig_dr  = sbdata_read_valid_i & sbreadondata_i;
  assign trig_any = trig_dw | trig_aw | trig_dr;
  // A same-cycle address write takes effect for the triggered access.
  assign eff_addr = sbaddress_write_valid_i ? sbaddress_i : addr_reg;

  dm_sba_lane_align u_lane_align (
    .wr_access (sbaccess_i),
    .wr_offset (eff_addr[1:0]),
    .wdata_in  (sbdata_i),
    .rd_access (access_reg),
    .rd_offset (addr_reg[1:0]),
    .rdata_in  (rdata_reg),
    .be        (be_next),
    .wdata     (wdata_next),
    .rdata     (rdata_lane)
  );

`ifdef SBA_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles + 1);
  logic [CntW-1:0] cnt_reg;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TimeoutCycles);
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg         <= IDLE;
      addr_reg          <= '0;
      access_reg        <= '0;
      autoinc_reg       <= 1'b0;
      rdata_reg         <= '0;
      err_reg           <= 1'b0;
      req_reg           <= 1'b0;
      add_reg           <= '0;
      we_reg            <= 1'b0;
      wdata_reg         <= '0;
      be_reg            <= '0;
      sbdata_reg        <= '0;
      sbdata_valid_reg  <= 1'b0;
      sberror_valid_reg <= 1'b0;
      sberror_reg       <= SBErrNone;
      busy_reg          <= 1'b0;
`ifdef SBA_TIMEOUT_EN
      cnt_reg           <= '0;
`endif
    end else begin
      sbdata_valid_reg  <= 1'b0;
      sberror_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (sbaddress_write_valid_i) addr_reg <= sbaddress_i;
          if (trig_any) begin
            if (sbaccess_i > SBAccess32) begin
              sberror_valid_reg <= 1'b1;
              sberror_reg       <= SBErrSize;
            end else if (sba_misaligned(sbaccess_i, eff_addr[1:0])) begin
              sberror_valid_reg <= 1'b1;
              sberror_reg       <= SBErrAlign;
            end else begin
              state_reg   <= REQ;
              req_reg     <= 1'b1;
              busy_reg    <= 1'b1;
              add_reg     <= BusWidth'({eff_addr[31:2], 2'b00});
              we_reg      <= trig_dw;
              wdata_reg   <= wdata_next;
              be_reg      <= be_next;
              access_reg  <= sbaccess_i;
              autoinc_reg <= sbautoincrement_i;
`ifdef SBA_TIMEOUT_EN
              cnt_reg     <= '0;
`endif
            end
          end
        end
        REQ: begin
          if (bus.gnt) begin
            req_reg   <= 1'b0;
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (bus.r_valid) begin
            rdata_reg <= bus.r_rdata;
            err_reg   <= bus.r_err;
            state_reg <= DONE;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          if (err_reg) begin
            sberror_valid_reg <= 1'b1;
            sberror_reg       <= SBErrBadAddr;
          end else begin
            if (!we_reg) begin
              sbdata_reg       <= rdata_lane;
              sbdata_valid_reg <= 1'b1;
            end
            if (autoinc_reg) addr_reg <= addr_reg + (32'd1 << access_reg);
          end
        end
        default: state_reg <= IDLE;
      endcase
`ifdef SBA_TIMEOUT_EN
      // Overrides the REQ/WAIT progress above once the budget is spent.
      if (state_reg == REQ || state_reg == WAIT) begin
        if (cnt_reg == CntW'(TimeoutCycles - 1)) begin
          state_reg         <= IDLE;
          req_reg           <= 1'b0;
          busy_reg          <= 1'b0;
          sberror_valid_reg <= 1'b1;
          sberror_reg       <= SBErrTimeout;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
`endif
    end
  end

  assign sbaddress_o     = addr_reg;
  assign sbdata_o        = sbdata_reg;
  assign sbdata_valid_o  = sbdata_valid_reg;
  assign sberror_valid_o = sberror_valid_reg;
  assign sberror_o       = sberror_reg;
  assign sbbusy_o        = busy_reg;
  assign bus.req         = req_reg;
  assign bus.add         = add_reg;
  assign bus.we          = we_reg;
  assign bus.wdata       = wdata_reg;
  assign bus.be          = be_reg;

endmodule
